jt49_mave_sched: RTL and testbench
==================================

// Module: jt49_mave_sched
// PURPOSE
//  Time-multiplexed moving-average engine shared by CH sample requesters (e.g. PSG channels A/B/C).
//  One delay RAM and one adder serve all channels; a round-robin arbiter grants requests.
//  Each granted sample goes through a 4-state read/accumulate/write sequence.
//  Output per sample: window mean over the last 2^DEPTH samples of that channel, tagged with its channel.
// PARAMETERS
//  CH     3   number of requesters/channels (1..8)
//  DEPTH  5   log2 of averaging window length (window = 2^DEPTH samples)
//  DW     8   sample width, unsigned
// PORTS
//  clk         in   1          clock
//  rst         in   1          reset, synchronous, active-high
//  cen         in   1          grant enable; new grants only when high
//  req         in   CH         per-channel request; hold with din until ack
//  din         in   CH*DW      packed samples, channel n at [n*DW +: DW]
//  ack         out  CH         one-cycle pulse: sample of channel n consumed
//  dout        out  DW         window mean of channel dout_ch
//  dout_ch     out  clog2(CH)  channel tag of dout
//  dout_valid  out  1          one-cycle strobe qualifying dout/dout_ch
//  busy        out  1          high during post-reset RAM clear and while a sample is in flight
// BEHAVIOUR
//  - Reset values: ack=0, dout=0, dout_ch=0, dout_valid=0, busy=1.
//    Reset also zeroes all sums and write pointers and sets the RR pointer to 0. State goes to CLR.
//  - CLR: writes 0 to RAM addresses 0..CH*2^DEPTH-1, one per cycle, ignoring cen.
//    Then IDLE; busy falls on the first IDLE cycle.
//  - IDLE: if cen && |req, grant the first requesting channel at or after rr_ptr (cyclic).
//    Latch ch and din[ch], set rr_ptr=ch+1 mod CH, go RD. Otherwise stay.
//  - RD: read RAM[{ch,wptr[ch]}] (oldest sample). Go ACC.
//  - ACC: diff = {1'b0,din_l} - {1'b0,old}, signed DW+1.
//    sum[ch] += sign-extended diff; sum is DW+DEPTH bits; never overflows or underflows. Go WR.
//  - WR: RAM[{ch,wptr[ch]}] = din_l; wptr[ch] += 1, wrapping mod 2^DEPTH; ack[ch]=1. Go IDLE.
//  - Output, registered in the cycle after WR: dout = sum[ch][DW+DEPTH-1:DEPTH] (truncating),
//    dout_ch = ch, dout_valid = 1.
//  - Latency: grant in IDLE at cycle t -> ack at t+3 -> dout_valid at t+4.
//    Peak throughput is one sample per 4 cycles total across all channels.
//  - A grant is committed: deasserting req after grant does not cancel it; ack still pulses.
//  - A req held after ack is treated as a new sample.
//  - cen low blocks new grants only; an in-flight sample completes.
//  - Reset mid-operation (any state): abort immediately, no ack, no dout_valid, then CLR sweep.
//  - ack is one-hot or zero; at most one channel is in flight.
//  - Channel sums are independent; the other channels' sums are untouched.
// CONFIGURATION
//  - JT49_MAVE_SCHED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr is unused.
//  - Not defined: round-robin as above.
// TESTING
//  1. rst 1 cycle, CH=3, DEPTH=5 -> busy high 96 cycles then low; dout=0, no ack during clear.
//  2. DEPTH=3, ch0 req held, din0=80 -> dout 10,20,..,80 on successive dout_valid, then steady 80, dout_ch=0.
//  3. After test 2, din0=0 -> dout 70,60,..,0, then steady 0 (no wrap to 255).
//  4. All req held, cen=1 -> ack order ch0,ch1,ch2,ch0..., 4 cycles apart; ch1/ch2 sums unaffected by ch0 data.
//  5. rst asserted during ACC of ch1 -> no ack/dout_valid; after clear, first ch1 sample 80 (DEPTH=3) -> dout=10.
//  6. With JT49_MAVE_SCHED_PRIO_EN, req0 and req2 held -> only ch0 acked; drop req0 -> ch2 acked next grant.

Source files
------------

// File: rtl/jt49_mave_sched_if.sv
// Request/ack and averaged-output bundle for jt49_mave_sched.
// The slave modport is the scheduler side; the master modport is the requester/observer side.
interface jt49_mave_sched_if #(
  parameter int unsigned CH = 3,
  parameter int unsigned DW = 8
);
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

  logic             cen;
  logic [CH-1:0]    req;
  logic [CH*DW-1:0] din;
  logic [CH-1:0]    ack;
  logic [DW-1:0]    dout;
  logic [CW-1:0]    dout_ch;
  logic             dout_valid;
  logic             busy;

  modport master (
    output cen, req, din,
    input  ack, dout, dout_ch, dout_valid, busy
  );

  modport slave (
    input  cen, req, din,
    output ack, dout, dout_ch, dout_valid, busy
  );
endinterface

// File: rtl/jt49_mave_sched.sv
// Time-multiplexed moving-average engine: one delay RAM and one adder shared by CH requesters.
// Define JT49_MAVE_SCHED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module jt49_mave_sched #(
  parameter int unsigned CH    = 3,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned DW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  jt49_mave_sched_if.slave bus
);
  localparam int unsigned CW     = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned AW     = CW + DEPTH;
  localparam int unsigned SW     = DW + DEPTH;
  localparam int unsigned NWORDS = CH << DEPTH;

  typedef enum logic [2:0] {CLR, IDLE, RD, ACC, WR} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_clr;
  logic [CW-1:0]    r_ch;
  logic [DW-1:0]    r_din;
  logic [DW-1:0]    r_old;
  logic [DEPTH-1:0] r_wptr [CH];
  logic [SW-1:0]    r_sum  [CH];
  logic [DW-1:0]    r_mem  [1 << AW];

  logic [CH-1:0]    r_ack;
  logic [DW-1:0]    r_dout;
  logic [CW-1:0]    r_dout_ch;
  logic             r_dout_valid;
  logic             r_busy;

  logic [CW-1:0]    w_base;
  logic [CW-1:0]    w_idx;
  logic [CW-1:0]    w_gnt;
  logic             w_hit;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_wdata;
  logic             w_we;
  logic signed [DW:0] w_diff;
  logic [SW-1:0]    w_dext;

`ifdef JT49_MAVE_SCHED_PRIO_EN
  assign w_base = '0;
`else
  logic [CW-1:0]    r_rr;
  assign w_base = r_rr;
`endif

  // First requester at or after w_base, scanning cyclically
  always_comb begin
    w_hit = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      w_idx = CW'((32'(w_base) + i) % CH);
      if (!w_hit && bus.req[w_idx]) begin
        w_hit = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_addr  = (r_state == CLR) ? r_clr : {r_ch, r_wptr[r_ch]};
  assign w_wdata = (r_state == CLR) ? '0 : r_din;
  assign w_we    = !rst && ((r_state == CLR) || (r_state == WR));
  assign w_diff  = $signed({1'b0, r_din}) - $signed({1'b0, r_old});
  assign w_dext  = SW'(w_diff);

  // Delay RAM holds no reset state; the CLR sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_wdata;
    if (r_state == RD) r_old <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= CLR;
      r_clr        <= '0;
      r_ch         <= '0;
      r_din        <= '0;
      r_ack        <= '0;
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b1;
`ifndef JT49_MAVE_SCHED_PRIO_EN
      r_rr         <= '0;
`endif
      for (int i = 0; i < CH; i++) begin
        r_wptr[i] <= '0;
        r_sum[i]  <= '0;
      end
    end else begin
      r_ack        <= '0;
      r_dout_valid <= 1'b0;
      case (r_state)
        CLR: begin
          r_clr <= r_clr + AW'(1);
          if (r_clr == AW'(NWORDS - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.cen && w_hit) begin
            r_ch    <= w_gnt;
            r_din   <= bus.din[32'(w_gnt) * DW +: DW];
            r_state <= RD;
            r_busy  <= 1'b1;
`ifndef JT49_MAVE_SCHED_PRIO_EN
            r_rr    <= (w_gnt == CW'(CH - 1)) ? '0 : w_gnt + CW'(1);
`endif
          end
        end
        RD: r_state <= ACC;
        ACC: begin
          // Window sum stays in range: it only ever holds 2^DEPTH unsigned samples
          r_sum[r_ch] <= r_sum[r_ch] + w_dext;
          r_ack       <= CH'(1) << r_ch;
          r_state     <= WR;
        end
        WR: begin
          r_wptr[r_ch] <= r_wptr[r_ch] + DEPTH'(1);
          r_dout       <= r_sum[r_ch][SW-1:DEPTH];
          r_dout_ch    <= r_ch;
          r_dout_valid <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= CLR;
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.dout       = r_dout;
  assign bus.dout_ch    = r_dout_ch;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_jt49_mave_sched.sv
// Bench for jt49_mave_sched: directed scenarios plus random traffic against a
// transaction-level model (sample windows, arbitration order, fixed 3/4-cycle latency).
module tb_jt49_mave_sched;
  localparam int unsigned CH     = 3;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned DW     = 8;
  localparam int unsigned WIN    = 1 << DEPTH;
  localparam int unsigned NWORDS = CH * WIN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jt49_mave_sched_if #(.CH(CH), .DW(DW)) bus();
  jt49_mave_sched #(.CH(CH), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int cyc = 0, free_at = 0, rr = 0;
  int hist [CH][WIN];
  int hp   [CH];
  int pend_ch = -1, pend_due = 0, pend_din = 0;
  int valid_due = -1, valid_ch = 0, valid_val = 0;

  // Stimulus state
  int            mode = 0;
  logic [CH-1:0] hold = '0;
  logic [CH-1:0] act  = '0;
  logic          cen_fix = 1'b1;
  logic [DW-1:0] dv [CH];
  int            rec_ch = 0;
  int            obs[$];
  int            ack_log[$];
  int            ack_cyc[$];
  bit            live = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_sample();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic sample_check();
    logic [CH-1:0] ea;
    int s;
    ea = '0;
    if (pend_ch >= 0 && pend_due == cyc) ea = CH'(1) << pend_ch;
    check("ack", bus.ack, ea);
    check("busy", bus.busy, cyc < free_at);
    check("dout_valid", bus.dout_valid, valid_due == cyc);
    if (valid_due == cyc) begin
      check("dout", bus.dout, valid_val);
      check("dout_ch", bus.dout_ch, valid_ch);
      if (valid_ch == rec_ch) obs.push_back(int'(bus.dout));
    end
    for (int n = 0; n < CH; n++)
      if (((bus.ack >> n) & CH'(1)) != 0) begin
        ack_log.push_back(n);
        ack_cyc.push_back(cyc);
      end
    if (pend_ch >= 0 && pend_due == cyc) begin
      hist[pend_ch][hp[pend_ch]] = pend_din;
      hp[pend_ch] = (hp[pend_ch] + 1) % WIN;
      s = 0;
      for (int k = 0; k < WIN; k++) s += hist[pend_ch][k];
      valid_val = s / WIN;
      valid_ch  = pend_ch;
      valid_due = cyc + 1;
      act &= ~(CH'(1) << pend_ch);
      pend_ch = -1;
    end
  endtask

  task automatic drive_and_model();
    logic [CH-1:0] r, m;
    int g, k;
    if (mode == 1) begin
      for (int n = 0; n < CH; n++) begin
        m = CH'(1) << n;
        if ((act & m) == 0 && n != pend_ch && $urandom_range(3) == 0) begin
          act |= m;
          dv[n] = rand_sample();
        end else if ((act & m) != 0 && n == pend_ch && $urandom_range(2) == 0) begin
          act &= ~m;  // withdraw after grant: the sample must still complete
        end
      end
      r = act;
      bus.cen = ($urandom_range(3) != 0);
    end else begin
      r = hold;
      bus.cen = cen_fix;
    end
    bus.req = r;
    for (int n = 0; n < CH; n++) bus.din[n*DW +: DW] = dv[n];
    if (cyc >= free_at && bus.cen && r != 0) begin
      g = -1;
`ifdef JT49_MAVE_SCHED_PRIO_EN
      for (int i = 0; i < CH; i++)
        if (g < 0 && ((r >> i) & CH'(1)) != 0) g = i;
`else
      for (int i = 0; i < CH; i++) begin
        k = (rr + i) % CH;
        if (g < 0 && ((r >> k) & CH'(1)) != 0) g = k;
      end
      rr = (g + 1) % CH;
`endif
      pend_ch  = g;
      pend_din = int'(dv[g]);
      pend_due = cyc + 3;
      free_at  = cyc + 4;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    sample_check();
    drive_and_model();
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    cyc++;
    if (live) sample_check();
    rst = 1'b1;
    pend_ch   = -1;
    valid_due = -1;
    rr        = 0;
    for (int c = 0; c < CH; c++) begin
      hp[c] = 0;
      for (int k = 0; k < WIN; k++) hist[c][k] = 0;
    end
    free_at = cyc + 1 + NWORDS;
    drive_and_model();
    @(negedge clk);
    cyc++;
    rst  = 1'b0;
    live = 1'b1;
    check("rst_dout", bus.dout, 0);
    check("rst_dout_ch", bus.dout_ch, 0);
    sample_check();
    drive_and_model();
    n = 1;
    while (n < 1000) begin
      step();
      if (!bus.busy) break;
      n++;
    end
    check("clear_len", n, NWORDS);
  endtask

  task automatic settle();
    mode = 0;
    hold = '0;
    repeat (10) step();
  endtask

  task automatic wait_obs(input int cnt, input string tag);
    int b;
    b = 0;
    while (obs.size() < cnt && b < 400) begin step(); b++; end
    if (obs.size() < cnt) check(tag, obs.size(), cnt);
  endtask

  task automatic wait_acks(input int cnt, input string tag);
    int b;
    b = 0;
    while (ack_log.size() < cnt && b < 400) begin step(); b++; end
    if (ack_log.size() < cnt) check(tag, ack_log.size(), cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, e;
    bus.req = '0;
    bus.cen = 1'b0;
    bus.din = '0;
    for (int n = 0; n < CH; n++) dv[n] = '0;

    // Clear sweep with every channel requesting: nothing may be granted until busy falls
    hold = '1;
    cen_fix = 1'b1;
    do_reset();
    settle();

    // Ramp-up of a constant 80 on ch0
    rec_ch = 0;
    obs.delete();
    dv[0] = 8'd80;
    hold  = 3'b001;
    wait_obs(12, "ramp_timeout");
    for (int k = 0; k < 12 && k < obs.size(); k++)
      check("ramp_up", obs[k], 10 * (((k + 1) < WIN) ? (k + 1) : WIN));

    // Decay to 0 without wrapping
    settle();
    obs.delete();
    dv[0] = 8'd0;
    hold  = 3'b001;
    wait_obs(10, "decay_timeout");
    for (int k = 0; k < 10 && k < obs.size(); k++)
      check("ramp_down", obs[k], (70 - 10 * k > 0) ? (70 - 10 * k) : 0);

    // All channels requesting: arbitration order, 4-cycle spacing, independent sums
    hold = '0;
    do_reset();
    dv[0] = 8'd200;
    dv[1] = 8'd40;
    dv[2] = 8'd8;
    rec_ch = 1;
    obs.delete();
    ack_log.delete();
    ack_cyc.delete();
    hold = 3'b111;
    wait_acks(6, "all_req_timeout");
    for (int i = 0; i < 6 && i < ack_log.size(); i++) begin
`ifdef JT49_MAVE_SCHED_PRIO_EN
      check("order_all", ack_log[i], 0);
`else
      check("order_all", ack_log[i], i % CH);
      if (i == 1 && obs.size() > 0) check("ch1_isolated", obs[0], 5);
`endif
      if (i > 0) check("ack_spacing", ack_cyc[i] - ack_cyc[i-1], 4);
    end

    // ch0 and ch2 competing
    ack_log.delete();
    hold = 3'b101;
    wait_acks(4, "pair_timeout");
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
`ifdef JT49_MAVE_SCHED_PRIO_EN
      check("order_pair", ack_log[i], 0);
`else
      check("order_pair", ack_log[i], (i % 2 == 0) ? 0 : 2);
`endif
    end
    ack_log.delete();
    hold = 3'b100;
    wait_acks(1, "ch2_timeout");
    if (ack_log.size() > 0) check("ch2_after_drop", ack_log[0], 2);

    // Reset while ch1 sits in ACC: sample aborted, then a clean restart
    settle();
    dv[1] = 8'd80;
    hold  = 3'b010;
    b = 0;
    while (pend_ch != 1 && b < 20) begin step(); b++; end
    if (pend_ch != 1) check("grant_ch1_timeout", pend_ch, 1);
    step();
    ack_log.delete();
    do_reset();
    check("abort_no_ack", ack_log.size(), 0);
    rec_ch = 1;
    obs.delete();
    wait_obs(1, "restart_timeout");
    if (obs.size() > 0) check("restart_ch1", obs[0], 10);

    // Random traffic, random cen, post-grant withdrawals
    settle();
    act  = '0;
    mode = 1;
    repeat (4000) step();
    settle();

    e = errors;
    $display("Result: errors=%0d of %0d checks", e, checks);
    $finish;
  end
endmodule
